prim_strb_unpacker: RTL
=======================

PRIM_STRB_UNPACKER -- requirements
Module: prim_strb_unpacker

Interface
REQ-001 Parameter InW, default 32: input word width; SHALL be an integer multiple of OutW.
REQ-002 Parameter OutW, default 8: output beat width.
REQ-003 Parameter ClearOnRead, default 1: zero each lane's stored data once that lane is read.
REQ-004 Derived: Lanes = InW/OutW; CntW = $clog2(Lanes)+1.
REQ-005 clk_i  input  1  clock.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 clr_i  input  1  synchronous flush.
REQ-008 wvalid_i  input  1  input word valid.
REQ-009 wdata_i  input  InW  input word; lane k = bits [k*OutW +: OutW].
REQ-010 wstrb_i  input  Lanes  lane enable; bit k set = lane k is emitted.
REQ-011 wready_o  output  1  input word accepted when wvalid_i && wready_o.
REQ-012 rvalid_o  output  1  output beat valid.
REQ-013 rdata_o  output  OutW  output beat data.
REQ-014 rlast_o  output  1  beat is the last enabled lane of its word.
REQ-015 rready_i  input  1  output beat consumed when rvalid_o && rready_i.
REQ-016 depth_o  output  CntW  number of enabled lanes still pending.

Function
REQ-017 Internal state: data_q (InW), mask_q (Lanes); idle when mask_q == 0.
REQ-018 On accept, data_q <= wdata_i and mask_q <= wstrb_i at the next edge.
REQ-019 rvalid_o = (mask_q != 0) && !clr_q; rdata_o = lane at index of lowest set bit of mask_q; rdata_o = 0 when idle.
REQ-020 rlast_o = rvalid_o && popcount(mask_q) == 1.
REQ-021 On pull, the lowest set bit of mask_q is cleared; if ClearOnRead, that lane of data_q is zeroed.
REQ-022 wready_o = !clr_q && (mask_q == 0 || (rlast_o && rready_i)), which allows back-to-back words with no bubble.
REQ-023 Simultaneous last pull and accept: the new word is loaded and the pull's clear is discarded.
REQ-024 Accepted word with wstrb_i == 0 is dropped: no beat, mask_q stays 0, wready_o stays high.
REQ-025 Lanes are emitted strictly ascending; disabled lanes are skipped with no idle cycle.
REQ-026 depth_o = popcount(mask_q); range 0..Lanes.
REQ-027 Latency (macro undefined): first beat is valid in the cycle after accept.
REQ-028 rvalid_o && !rready_i && !clr_i SHALL keep rvalid_o, rdata_o and rlast_o stable on the next cycle.
REQ-029 clr_i sampled into clr_q. While clr_i is high, mask_q and data_q are zeroed at the next edge. While clr_q is high, wready_o = 0 and rvalid_o = 0. clr_i overrides simultaneous accept and pull.

Reset
REQ-030 Reset SHALL set data_q = 0, mask_q = 0 and clr_q = 1, so wready_o = 0 and rvalid_o = 0 in the first cycle after release.
REQ-031 Reset values of outputs: rdata_o = 0, rlast_o = 0, depth_o = 0.
REQ-032 Reset asserted mid-word discards all pending lanes; no beat is emitted after release.

Configuration
REQ-033 Macro PRIM_STRB_UNPACKER_SKID_EN, when defined, adds a 1-entry output register holding rdata_o and rlast_o, with rvalid_o driven from that register.
REQ-034 With the macro defined:
- latency is 2 cycles from accept;
- full throughput of 1 beat/cycle is kept under continuous rready_i;
- clr_i also empties the output register;
- depth_o counts the register entry.
REQ-035 Without the macro, outputs are driven directly from data_q/mask_q per REQ-019 and REQ-020.

Verification
REQ-036 InW=32/OutW=8, word 0x44332211, strb 1111, rready_i held high -> beats 11, 22, 33, 44 on consecutive cycles; rlast_o only on 44; depth_o 4, 3, 2, 1, 0.
REQ-037 Word 0xDDCCBBAA, strb 1010 -> beats BB then DD; rlast_o on DD; depth_o 2, 1.
REQ-038 Two words back-to-back (strb 0011, then 0100) with rready_i high -> wready_o high on the last-beat cycle; beats emitted without a bubble; second word yields a single beat with rlast_o = 1.
REQ-039 strb 0000 -> word accepted, rvalid_o stays 0, wready_o stays 1.
REQ-040 rready_i held low for 3 cycles on the second beat -> rdata_o/rlast_o stable for those cycles; clr_i pulsed mid-word -> rvalid_o = 0 and depth_o = 0 the next cycle.
REQ-041 rst_ni asserted with 2 lanes pending -> all outputs 0; wready_o = 0 for the first cycle after release, 1 afterwards.

Source files
------------

// File: rtl/prim_strb_unpacker.sv
// prim_strb_unpacker: splits a wide input word into narrow output beats,
// emitting only the lanes enabled by the word's strobe, lowest lane first.
// Optional feature macro: PRIM_STRB_UNPACKER_SKID_EN adds a one-entry output
// register in front of rvalid_o/rdata_o/rlast_o (two-cycle latency, full rate).
module prim_strb_unpacker #(
  parameter int unsigned InW         = 32,
  parameter int unsigned OutW        = 8,
  parameter bit          ClearOnRead = 1'b1,
  localparam int unsigned Lanes      = InW / OutW,
  localparam int unsigned CntW       = $clog2(Lanes) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  input  logic [InW-1:0]   wdata_i,
  input  logic [Lanes-1:0] wstrb_i,
  output logic             wready_o,
  output logic             rvalid_o,
  output logic [OutW-1:0]  rdata_o,
  output logic             rlast_o,
  input  logic             rready_i,
  output logic [CntW-1:0]  depth_o
);

  logic [InW-1:0]   data_q;
  logic [Lanes-1:0] mask_q;
  logic             clr_q;

  logic [Lanes-1:0] low_oh;
  logic [InW-1:0]   lane_clr;
  logic [OutW-1:0]  core_data;
  logic [CntW-1:0]  pop;
  logic             core_valid;
  logic             core_last;
  logic             core_take;
  logic             core_pull;
  logic             accept;

  // Find the lowest pending lane: its one-hot position and its data.
  always_comb begin
    logic found;
    found     = 1'b0;
    low_oh    = '0;
    core_data = '0;
    for (int k = 0; k < Lanes; k++) begin
      if (mask_q[k] && !found) begin
        found     = 1'b1;
        low_oh[k] = 1'b1;
        core_data = data_q[k*OutW +: OutW];
      end
    end
  end

  // Widen the one-hot lane select into a bit mask over the stored word.
  always_comb begin
    lane_clr = '0;
    for (int k = 0; k < Lanes; k++) begin
      lane_clr[k*OutW +: OutW] = {OutW{low_oh[k]}};
    end
  end

  // Count pending lanes in the word buffer.
  always_comb begin
    pop = '0;
    for (int k = 0; k < Lanes; k++) begin
      pop = pop + CntW'(mask_q[k]);
    end
  end

  assign core_valid = (mask_q != '0) && !clr_q;
  assign core_last  = core_valid && (pop == CntW'(1));
  assign core_pull  = core_valid && core_take;
  // A new word may land in the same cycle its predecessor's last beat leaves.
  assign wready_o   = !clr_q && ((mask_q == '0) || (core_last && core_take));
  assign accept     = wvalid_i && wready_o;

  // Word buffer: flush wins, then load of a new word, then retire one lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      mask_q <= '0;
      clr_q  <= 1'b1;
    end else begin
      clr_q <= clr_i;
      if (clr_i) begin
        data_q <= '0;
        mask_q <= '0;
      end else if (accept) begin
        data_q <= wdata_i;
        mask_q <= wstrb_i;
      end else if (core_pull) begin
        mask_q <= mask_q & ~low_oh;
        if (ClearOnRead) begin
          data_q <= data_q & ~lane_clr;
        end
      end
    end
  end

`ifdef PRIM_STRB_UNPACKER_SKID_EN
  logic            out_valid_q;
  logic [OutW-1:0] out_data_q;
  logic            out_last_q;

  // The buffer may advance whenever the output register is free or draining.
  assign core_take = !out_valid_q || rready_i;

  // Output register: refilled from the buffer each time it can move.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (clr_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (core_take) begin
      out_valid_q <= core_valid;
      out_data_q  <= core_data;
      out_last_q  <= core_last;
    end
  end

  assign rvalid_o = out_valid_q && !clr_q;
  assign rdata_o  = out_data_q;
  assign rlast_o  = out_last_q && rvalid_o;
  assign depth_o  = pop + CntW'(out_valid_q);
`else
  assign core_take = rready_i;
  assign rvalid_o  = core_valid;
  assign rdata_o   = core_data;
  assign rlast_o   = core_last;
  assign depth_o   = pop;
`endif

endmodule
